// File: rtl/fetch_redirect_unit_if.sv
// Fetch redirect bundle: branch-resolution inputs, fetch handshake and
// the PC/squash outputs of fetch_redirect_unit.
// Optional branch statistics ports are present when BRANCH_STATS_EN is defined.
interface fetch_redirect_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 3
);
    logic             fetch_fire;
    logic             branch_pending;
    logic             kill;
    logic             resolve;
    logic [XLEN-1:0]  branch_target;
    logic [XLEN-1:0]  proc2Imem_addr;
    logic             fetch_valid;
    logic             squash;
    logic [CNT_W-1:0] squash_count;
    logic [CNT_W-1:0] spec_count;
`ifdef BRANCH_STATS_EN
    logic [15:0]      taken_cnt;
    logic [15:0]      not_taken_cnt;
`endif

    // Environment side: drives fetch and branch-resolution inputs.
    modport master (
        output fetch_fire, branch_pending, kill, resolve, branch_target,
        input  proc2Imem_addr, fetch_valid, squash, squash_count, spec_count
`ifdef BRANCH_STATS_EN
        , input taken_cnt, not_taken_cnt
`endif
    );

    // Redirect unit side.
    modport slave (
        input  fetch_fire, branch_pending, kill, resolve, branch_target,
        output proc2Imem_addr, fetch_valid, squash, squash_count, spec_count
`ifdef BRANCH_STATS_EN
        , output taken_cnt, not_taken_cnt
`endif
    );
endinterface

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: owns the fetch PC, limits speculative fetch past an
// unresolved branch to MAX_SPEC instructions, and on a taken branch (kill)
// redirects to the target and emits a one-cycle squash pulse carrying the
// number of wrong-path instructions to flush.
// Optional feature macro: BRANCH_STATS_EN (taken / not-taken event counters).
module fetch_redirect_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int              MAX_SPEC = 4,
    parameter int              CNT_W    = 3
) (
    input  logic clock,
    input  logic reset,
    fetch_redirect_unit_if.slave fr
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SPEC   = 2'd1,
        ST_SQUASH = 2'd2
    } state_t;

    localparam logic [XLEN-1:0]  PC_STEP    = XLEN'(3'd4);
    localparam logic [XLEN-1:0]  ALIGN_MASK = ~(XLEN'(2'b11));
    localparam logic [CNT_W-1:0] MAX_SPEC_C = CNT_W'(MAX_SPEC);

    state_t           state_r;
    logic [XLEN-1:0]  pc_r;
    logic [CNT_W-1:0] spec_count_r;
    logic             squash_r;
    logic [CNT_W-1:0] squash_count_r;
    logic             fetch_valid_s;
    logic             accept_s;
`ifdef BRANCH_STATS_EN
    logic [15:0]      taken_cnt_r;
    logic [15:0]      not_taken_cnt_r;
`endif

    // Fetch permission depends only on state and the speculative count.
    always_comb begin
        fetch_valid_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                fetch_valid_s = 1'b1;
            end
            ST_SPEC: begin
                if (spec_count_r < MAX_SPEC_C) begin
                    fetch_valid_s = 1'b1;
                end else begin
                    fetch_valid_s = 1'b0;
                end
            end
            ST_SQUASH: begin
                fetch_valid_s = 1'b0;
            end
            default: begin
                fetch_valid_s = 1'b0;
            end
        endcase
    end

    assign accept_s = fr.fetch_fire & fetch_valid_s;

    // Redirect FSM: PC, speculative count and squash pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ST_RUN;
            pc_r           <= RESET_PC;
            spec_count_r   <= {CNT_W{1'b0}};
            squash_r       <= 1'b0;
            squash_count_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_RUN: begin
                    squash_r       <= 1'b0;
                    squash_count_r <= {CNT_W{1'b0}};
                    spec_count_r   <= {CNT_W{1'b0}};
                    // A fetch here is the branch itself or older: never counted.
                    if (accept_s) begin
                        pc_r <= pc_r + PC_STEP;
                    end
                    if (fr.branch_pending) begin
                        state_r <= ST_SPEC;
                    end
                end
                ST_SPEC: begin
                    if (fr.kill) begin
                        // Same-cycle fetch is wrong-path: dropped and flushed.
                        pc_r           <= fr.branch_target & ALIGN_MASK;
                        squash_count_r <= spec_count_r + {{(CNT_W-1){1'b0}}, accept_s};
                        squash_r       <= 1'b1;
                        state_r        <= ST_SQUASH;
                    end else if (fr.resolve) begin
                        if (accept_s) begin
                            pc_r <= pc_r + PC_STEP;
                        end
                        spec_count_r <= {CNT_W{1'b0}};
                        state_r      <= ST_RUN;
                    end else if (accept_s) begin
                        pc_r         <= pc_r + PC_STEP;
                        spec_count_r <= spec_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_SQUASH: begin
                    // One bubble cycle; a new pending branch is picked up in RUN.
                    squash_r       <= 1'b0;
                    squash_count_r <= {CNT_W{1'b0}};
                    spec_count_r   <= {CNT_W{1'b0}};
                    state_r        <= ST_RUN;
                end
                default: begin
                    squash_r       <= 1'b0;
                    squash_count_r <= {CNT_W{1'b0}};
                    spec_count_r   <= {CNT_W{1'b0}};
                    state_r        <= ST_RUN;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating counters of branch outcomes seen while speculating.
    always_ff @(posedge clock) begin
        if (reset) begin
            taken_cnt_r     <= 16'h0000;
            not_taken_cnt_r <= 16'h0000;
        end else if (state_r == ST_SPEC) begin
            if (fr.kill) begin
                if (taken_cnt_r != 16'hFFFF) begin
                    taken_cnt_r <= taken_cnt_r + 16'd1;
                end
            end else if (fr.resolve) begin
                if (not_taken_cnt_r != 16'hFFFF) begin
                    not_taken_cnt_r <= not_taken_cnt_r + 16'd1;
                end
            end
        end
    end

    assign fr.taken_cnt     = taken_cnt_r;
    assign fr.not_taken_cnt = not_taken_cnt_r;
`endif

    assign fr.proc2Imem_addr = pc_r;
    assign fr.fetch_valid    = fetch_valid_s;
    assign fr.squash         = squash_r;
    assign fr.squash_count   = squash_count_r;
    assign fr.spec_count     = spec_count_r;
endmodule
